// File: rtl/led_pio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_pio_ctrl
//  Description : Fabric stage on the soc_system leds2 PIO conduit. Decodes the
//                8-bit HPS command into animated LED patterns and debounces
//                four push-keys into a status nibble plus press pulses.
//  Ports       : clk_clk        in   system clock
//                reset_reset_n  in   asynchronous active-low reset
//                pio_cmd_i[7:0] in   [7:6] mode, [5:0] arg
//                key_n_i[3:0]   in   raw active-low keys (async, bouncy)
//                led_o[7:0]     out  LED drive, 1 = lit, registered
//                pio_status_o   out  debounced pressed flags, registered
//                key_event_o    out  one-cycle pulse per debounced press
//  Revision    : 1.0  initial release
// ============================================================================
module led_pio_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int DEB_TICKS = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] pio_cmd_i,
    input  logic [3:0] key_n_i,
    output logic [7:0] led_o,
    output logic [3:0] pio_status_o,
    output logic [3:0] key_event_o
);

    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_DW = $clog2(DEB_TICKS + 1);
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEB_TICKS - 1);

    localparam logic [1:0] c_MODE_STATIC = 2'b00;
    localparam logic [1:0] c_MODE_BLINK  = 2'b01;
    localparam logic [1:0] c_MODE_RING   = 2'b10;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b11;

    // ------------------------------------------------------------------
    // Prescaler: free running, never disturbed by command changes.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_presc == c_TICK_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command capture and pattern engine
    // ------------------------------------------------------------------
    logic [7:0] r_cmd_q;
    logic [5:0] r_rate;
    logic [7:0] r_pat;
    logic       r_dir_right;
    logic [7:0] r_led;

    logic       w_chg;
    logic [1:0] w_mode;
    logic [5:0] w_arg;
    logic       w_step;
    logic [7:0] w_init_pat;
    logic [7:0] w_next_pat;
    logic       w_next_dir;
    logic [7:0] w_shl;
    logic [7:0] w_shr;

    assign w_chg  = (pio_cmd_i != r_cmd_q);
    assign w_mode = r_cmd_q[7:6];
    assign w_arg  = r_cmd_q[5:0];
    assign w_step = w_tick && (r_rate == w_arg);
    assign w_shl  = {r_pat[6:0], 1'b0};
    assign w_shr  = {1'b0, r_pat[7:1]};

    // The restart value is taken from the incoming command, not cmd_q, so
    // the new pattern is already loaded when cmd_q catches up.
    always_comb begin
        w_init_pat = 8'h00;
        case (pio_cmd_i[7:6])
            c_MODE_BLINK:  w_init_pat = 8'hFF;
            c_MODE_RING:   w_init_pat = 8'h01;
            c_MODE_BOUNCE: w_init_pat = 8'h01;
            default:       w_init_pat = 8'h00;
        endcase
    end

    always_comb begin
        w_next_pat = r_pat;
        w_next_dir = r_dir_right;
        case (w_mode)
            c_MODE_BLINK: w_next_pat = ~r_pat;
            c_MODE_RING:  w_next_pat = {r_pat[6:0], r_pat[7]};
            c_MODE_BOUNCE: begin
                // Direction flips on arrival at an end so each endpoint is
                // displayed for exactly one step per pass.
                if (!r_dir_right) begin
                    w_next_pat = w_shl;
                    if (w_shl == 8'h80) begin
                        w_next_dir = 1'b1;
                    end
                end else begin
                    w_next_pat = w_shr;
                    if (w_shr == 8'h01) begin
                        w_next_dir = 1'b0;
                    end
                end
            end
            default: w_next_pat = r_pat;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cmd_q     <= 8'h00;
            r_rate      <= 6'd0;
            r_pat       <= 8'h00;
            r_dir_right <= 1'b0;
        end else begin
            r_cmd_q <= pio_cmd_i;
            // A command change wins over a coincident step.
            if (w_chg) begin
                r_rate      <= 6'd0;
                r_pat       <= w_init_pat;
                r_dir_right <= 1'b0;
            end else if (w_tick) begin
                if (w_step) begin
                    r_rate      <= 6'd0;
                    r_pat       <= w_next_pat;
                    r_dir_right <= w_next_dir;
                end else begin
                    r_rate <= r_rate + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_led <= 8'h00;
        end else if (w_mode == c_MODE_STATIC) begin
            r_led <= {2'b00, w_arg};
        end else begin
            r_led <= r_pat;
        end
    end

    assign led_o = r_led;

    // ------------------------------------------------------------------
    // Key synchroniser and debouncers (active-low, reset = released)
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_deb_n;
    logic [3:0] r_status;
    logic [3:0] r_event;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= key_n_i;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        logic            r_deb_n;
        logic [c_DW-1:0] r_cnt;

        // Any cycle that agrees with the accepted level restarts the count,
        // so a single-cycle glitch costs a full new debounce window.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_deb_n <= 1'b1;
                r_cnt   <= '0;
            end else if (r_sync2[gi] == r_deb_n) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (r_cnt == c_DEB_LAST) begin
                    r_deb_n <= r_sync2[gi];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_deb_n[gi] = r_deb_n;
    end

    // r_status is the previous pressed state, so the pulse lines up with
    // the cycle in which the status bit rises.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_status <= 4'h0;
            r_event  <= 4'h0;
        end else begin
            r_status <= ~w_deb_n;
            r_event  <= ~w_deb_n & ~r_status;
        end
    end

    assign pio_status_o = r_status;
    assign key_event_o  = r_event;

endmodule
`default_nettype wire

// File: tb/tb_led_pio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_pio_ctrl
//  Description : Self-checking bench for led_pio_ctrl. A reference model
//                predicts every cycle's outputs into a scoreboard queue that
//                a negedge monitor drains and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pio_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pio_cmd;
    logic [3:0] key_n;
    logic [7:0] led;
    logic [3:0] status;
    logic [3:0] kev;

    always #5 clk = ~clk;

    led_pio_ctrl #(
        .TICK_DIV  (TD),
        .DEB_TICKS (DB)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_cmd_i     (pio_cmd),
        .key_n_i       (key_n),
        .led_o         (led),
        .pio_status_o  (status),
        .key_event_o   (kev)
    );

    typedef struct packed {
        logic [7:0] led;
        logic [3:0] st;
        logic [3:0] ev;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    bit   mon_en  = 1'b0;
    bit   model_en = 1'b0;
    int   ev2_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Edges are numbered from 1 after reset release; a
    // tick lands on every edge that is a multiple of TD. Patterns are a
    // closed-form function of the number of steps since the last command.
    // ------------------------------------------------------------------
    int         m_edge;
    int         m_chg_edge;
    logic [7:0] m_cmdq;
    logic [7:0] m_pat;
    logic [7:0] m_led_last;
    logic [3:0] m_d1, m_d2;
    logic [3:0] m_deb, m_deb_prev;
    int         m_start[4];

    function automatic int ticks_upto(input int m);
        return m / TD;
    endfunction

    function automatic logic [7:0] pat_of(input logic [1:0] mode, input int k);
        int p;
        case (mode)
            2'd1: return (k % 2 == 0) ? 8'hFF : 8'h00;
            2'd2: return 8'(1 << (k % 8));
            2'd3: begin
                p = k % 14;
                if (p > 7) p = 14 - p;
                return 8'(1 << p);
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_edge     = 0;
        m_chg_edge = 0;
        m_cmdq     = 8'h00;
        m_pat      = 8'h00;
        m_led_last = 8'h00;
        m_d1       = 4'hF;
        m_d2       = 4'hF;
        m_deb      = 4'hF;
        m_deb_prev = 4'hF;
        for (int i = 0; i < 4; i++) m_start[i] = -1;
    endtask

    always @(posedge clk) begin
        int         mm;
        int         steps;
        logic [3:0] syn;
        exp_t       e;
        if (model_en) begin
            mm = m_edge + 1;
            e.led = (m_cmdq[7:6] == 2'b00) ? {2'b00, m_cmdq[5:0]} : m_pat;
            if (pio_cmd != m_cmdq) m_chg_edge = mm;
            m_cmdq = pio_cmd;
            steps  = (ticks_upto(mm) - ticks_upto(m_chg_edge)) / (int'(m_cmdq[5:0]) + 1);
            m_pat  = pat_of(m_cmdq[7:6], steps);
            syn  = m_d2;
            m_d2 = m_d1;
            m_d1 = key_n;
            for (int i = 0; i < 4; i++) begin
                e.st[i] = ~m_deb[i];
                e.ev[i] = ~m_deb[i] & m_deb_prev[i];
            end
            m_deb_prev = m_deb;
            for (int i = 0; i < 4; i++) begin
                if (syn[i] == m_deb[i]) begin
                    m_start[i] = -1;
                end else begin
                    if (m_start[i] < 0) m_start[i] = mm;
                    if (ticks_upto(mm) - ticks_upto(m_start[i] - 1) >= DB) begin
                        m_deb[i]   = syn[i];
                        m_start[i] = -1;
                    end
                end
            end
            m_edge     = mm;
            m_led_last = e.led;
            sb_q.push_back(e);
        end
    end

    // Monitor: drains one prediction per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("led",    32'(led),    32'(e.led));
            check("status", 32'(status), 32'(e.st));
            check("event",  32'(kev),    32'(e.ev));
            if (kev[2]) ev2_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int kp;
        rst_n   = 1'b0;
        pio_cmd = 8'hFF;
        key_n   = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led",    32'(led),    32'h00);
        check("reset_status", 32'(status), 32'h0);
        check("reset_event",  32'(kev),    32'h0);

        rst_n    = 1'b1;
        model_en = 1'b1;
        mon_en   = 1'b1;
        cyc(20);

        pio_cmd = 8'h2A; cyc(110);
        pio_cmd = 8'h80; cyc(40);
        pio_cmd = 8'hC1; cyc(130);

        // Key 2: press, glitch after two ticks, hold, then release.
        ev2_cnt = 0;
        key_n = 4'b1011; cyc(8);
        key_n = 4'b1111; cyc(1);
        key_n = 4'b1011; cyc(40);
        key_n = 4'b1111; cyc(40);
        check("key2_event_count", 32'(ev2_cnt), 32'd1);

        // Randomised commands and bursty key activity.
        kp = 60;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) kp = ($urandom_range(0, 1) != 0) ? 4 : 60;
            if ($urandom_range(0, 24) == 0) begin
                pio_cmd[7:6] = 2'($urandom_range(0, 3));
                pio_cmd[5:0] = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, kp) == 0) key_n[i] = ~key_n[i];
            end
            cyc(1);
        end

        // Command change landing exactly on a ring step at 0x10.
        key_n   = 4'hF;
        pio_cmd = 8'h80;
        cyc(12);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            cyc(1);
            if (m_pat == 8'h10 && (m_edge % TD) == 0) found = 1'b1;
        end
        check("ring_at_10_found", 32'(found), 32'd1);
        cyc(3);
        pio_cmd = 8'h81;
        cyc(20);

        // Asynchronous reset in the middle of BLINK with a key held.
        key_n   = 4'b1110;
        pio_cmd = 8'h40;
        cyc(30);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            cyc(1);
            if (m_led_last == 8'hFF) found = 1'b1;
        end
        check("blink_ff_found", 32'(found), 32'd1);
        #2;
        mon_en   = 1'b0;
        model_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_rst_led",    32'(led),    32'h00);
        check("async_rst_status", 32'(status), 32'h0);
        check("async_rst_event",  32'(kev),    32'h0);
        sb_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
